// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer for the 5-stage MIPS core: load-use stall, branch flush, dmem freeze, drain/halt.
// Latency: control outputs are combinational from state and inputs (0 cycles); state and counters are registered.
// Backpressure: a busy data memory freezes the pipe for at most MEM_TIMEOUT cycles; HAZARD_PERF_EN adds stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rt,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    input  logic        halt_req,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_bubble,
    output logic        exmem_write,
    output logic        memwb_bubble,
    output logic        halted,
    output logic        mem_error
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
        logic halted;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN = '{
        pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_write: 1'b1,
        idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0, halted: 1'b0
    };
    localparam ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
        idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1, halted: 1'b0
    };
    localparam ctrl_t CTRL_HALT = '{
        pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_write: 1'b0,
        idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b0, halted: 1'b1
    };

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  wait_cnt;
    logic [7:0]  wait_cnt_nxt;
    logic [3:0]  drain_cnt;
    logic [3:0]  drain_cnt_nxt;
    logic        mem_error_set;
    logic        load_use;
    logic        mem_stall;
    ctrl_t       ctrl;

    assign load_use  = idex_memread && (idex_rt != 5'd0) &&
                       ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    assign mem_stall = dmem_req && !dmem_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            wait_cnt  <= 8'd0;
            drain_cnt <= 4'd0;
            mem_error <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            drain_cnt <= drain_cnt_nxt;
            if (mem_error_set) begin
                mem_error <= 1'b1;
            end
        end
    end

    always_comb begin
        ctrl          = CTRL_RUN;
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        drain_cnt_nxt = drain_cnt;
        mem_error_set = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    ctrl         = CTRL_FREEZE;
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = 8'd1;
                end else if (ex_branch_taken) begin
                    ctrl.ifid_flush  = 1'b1;
                    ctrl.idex_bubble = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_write    = 1'b0;
                    ctrl.ifid_write  = 1'b0;
                    ctrl.idex_bubble = 1'b1;
                end else if (halt_req) begin
                    ctrl.pc_write  = 1'b0;
                    ctrl.ifid_flush = 1'b1;
                    state_nxt      = ST_DRAIN;
                    drain_cnt_nxt  = 4'd0;
                end
            end
            ST_MEM_WAIT: begin
                // Branch and load-use inputs are frozen with the pipe, so they are simply re-seen in RUN.
                if (dmem_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt     = ST_RUN;
                    wait_cnt_nxt  = 8'd0;
                    mem_error_set = 1'b1;
                end else begin
                    ctrl         = CTRL_FREEZE;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ST_DRAIN: begin
                ctrl.pc_write    = 1'b0;
                ctrl.ifid_flush  = 1'b1;
                ctrl.idex_bubble = 1'b1;
                if (mem_stall) begin
                    // ID/EX must hold too, else the bubble would overwrite the instruction stuck in EX.
                    ctrl.idex_write   = 1'b0;
                    ctrl.exmem_write  = 1'b0;
                    ctrl.memwb_bubble = 1'b1;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt     = ST_HALTED;
                    drain_cnt_nxt = 4'd0;
                end else begin
                    drain_cnt_nxt = drain_cnt + 4'd1;
                end
            end
            ST_HALTED: begin
                ctrl = CTRL_HALT;
                if (!halt_req) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        // Reset must present RUN defaults at once, not only after the state register settles.
        if (!reset_n) begin
            ctrl = CTRL_RUN;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign ifid_write   = ctrl.ifid_write;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_write   = ctrl.idex_write;
    assign idex_bubble  = ctrl.idex_bubble;
    assign exmem_write  = ctrl.exmem_write;
    assign memwb_bubble = ctrl.memwb_bubble;
    assign halted       = ctrl.halted;

`ifdef HAZARD_PERF_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (state == ST_MEM_WAIT) ||
                       ((state == ST_RUN) && !mem_stall && !ex_branch_taken && load_use);
    assign flush_evt = (state == ST_RUN) && !mem_stall && ex_branch_taken;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (stall_evt && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush_evt && (flush_cnt != 32'hFFFF_FFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

    a_halt_no_write: assert property (@(posedge clock) disable iff (!reset_n)
        halted |-> !(pc_write || ifid_write || idex_write || exmem_write));
    a_wait_bound: assert property (@(posedge clock) disable iff (!reset_n)
        wait_cnt <= WAIT_LIMIT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios with literal expectations, then randomized traffic vs a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT  = 16;
    localparam int DRAIN_CYCLES = 4;

    // Observed vector order: pc_write ifid_write ifid_flush idex_write idex_bubble exmem_write memwb_bubble halted mem_error
    localparam logic [8:0] L_DEF     = 9'b110101000;
    localparam logic [8:0] L_DEF_E   = 9'b110101001;
    localparam logic [8:0] L_LU      = 9'b000111000;
    localparam logic [8:0] L_BR      = 9'b111111000;
    localparam logic [8:0] L_FRZ     = 9'b000000100;
    localparam logic [8:0] L_FRZ_E   = 9'b000000101;
    localparam logic [8:0] L_HENT_E  = 9'b011101001;
    localparam logic [8:0] L_DRN_E   = 9'b011111001;
    localparam logic [8:0] L_HLT_E   = 9'b000000011;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic [4:0] id_rs = 5'd0;
    logic [4:0] id_rt = 5'd0;
    logic       id_uses_rt = 1'b0;
    logic       idex_memread = 1'b0;
    logic [4:0] idex_rt = 5'd0;
    logic       ex_branch_taken = 1'b0;
    logic       dmem_req = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       halt_req = 1'b0;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
    logic       exmem_write, memwb_bubble, halted, mem_error;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic [31:0] m_stalls = 32'd0;
    logic [31:0] m_flushes = 32'd0;
`endif

    int checks = 0;
    int errs = 0;

    // Model: m_wait = frozen cycles so far in a memory wait (0 = none); m_drain_left = drain cycles still owed.
    int m_wait = 0;
    int m_drain_left = 0;
    bit m_halted = 1'b0;
    bit m_err = 1'b0;

    logic [8:0] obs;
    assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                  exmem_write, memwb_bubble, halted, mem_error};

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .idex_memread   (idex_memread),
        .idex_rt        (idex_rt),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .halt_req       (halt_req),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_write     (idex_write),
        .idex_bubble    (idex_bubble),
        .exmem_write    (exmem_write),
        .memwb_bubble   (memwb_bubble),
        .halted         (halted),
        .mem_error      (mem_error)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    always #5 clock = ~clock;

    function automatic bit f_load_use();
        return idex_memread && (idex_rt != 5'd0) &&
               ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    endfunction

    function automatic bit f_mem_stall();
        return dmem_req && !dmem_ready;
    endfunction

    function automatic logic [8:0] model_out();
        logic [7:0] c;
        c = 8'b11010100;
        if (reset_n) begin
            if (m_halted) begin
                c = 8'b00000001;
            end else if (m_drain_left > 0) begin
                c = f_mem_stall() ? 8'b01101010 : 8'b01111100;
            end else if (m_wait > 0) begin
                if (!dmem_ready && (m_wait < MEM_TIMEOUT)) c = 8'b00000010;
            end else if (f_mem_stall()) begin
                c = 8'b00000010;
            end else if (ex_branch_taken) begin
                c = 8'b11111100;
            end else if (f_load_use()) begin
                c = 8'b00011100;
            end else if (halt_req) begin
                c = 8'b01110100;
            end
        end
        return {c, m_err};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_wait       <= 0;
            m_drain_left <= 0;
            m_halted     <= 1'b0;
            m_err        <= 1'b0;
`ifdef HAZARD_PERF_EN
            m_stalls     <= 32'd0;
            m_flushes    <= 32'd0;
`endif
        end else if (m_halted) begin
            if (!halt_req) m_halted <= 1'b0;
        end else if (m_drain_left > 0) begin
            if (!f_mem_stall()) begin
                m_drain_left <= m_drain_left - 1;
                if (m_drain_left == 1) m_halted <= 1'b1;
            end
        end else if (m_wait > 0) begin
`ifdef HAZARD_PERF_EN
            if (m_stalls != 32'hFFFF_FFFF) m_stalls <= m_stalls + 32'd1;
`endif
            if (dmem_ready) begin
                m_wait <= 0;
            end else if (m_wait == MEM_TIMEOUT) begin
                m_wait <= 0;
                m_err  <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (f_mem_stall()) begin
            m_wait <= 1;
        end else if (ex_branch_taken) begin
`ifdef HAZARD_PERF_EN
            if (m_flushes != 32'hFFFF_FFFF) m_flushes <= m_flushes + 32'd1;
`endif
        end else if (f_load_use()) begin
`ifdef HAZARD_PERF_EN
            if (m_stalls != 32'hFFFF_FFFF) m_stalls <= m_stalls + 32'd1;
`endif
        end else if (halt_req) begin
            m_drain_left <= DRAIN_CYCLES;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        logic [8:0] exp_v;
        exp_v = model_out();
        checks++;
        if (obs !== exp_v) begin
            errs++;
            $display("FAIL model_cmp t=%0t: got %b expected %b", $time, obs, exp_v);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        if ((stall_cnt !== m_stalls) || (flush_cnt !== m_flushes)) begin
            errs++;
            $display("FAIL perf_cmp t=%0t: got %0d/%0d expected %0d/%0d",
                     $time, stall_cnt, flush_cnt, m_stalls, m_flushes);
        end
`endif
    end

    task automatic check_lit(input string name, input logic [8:0] want);
        checks++;
        if (obs !== want) begin
            errs++;
            $display("FAIL %s t=%0t: got %b expected %b", name, $time, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; idex_memread = 1'b0; idex_rt = 5'd0;
        ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #2 check_lit("reset", L_DEF);
        #9 reset_n = 1'b1;

        // Load-use on rs, then cleared, then rt==0 never stalls
        tick(); idex_memread = 1'b1; idex_rt = 5'd5; id_rs = 5'd5;
        #2 check_lit("load_use_rs", L_LU);
        tick(); set_idle();
        #2 check_lit("load_use_clear", L_DEF);
        tick(); idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
        #2 check_lit("load_use_rt0", L_DEF);
        tick(); idex_rt = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        #2 check_lit("load_use_rt", L_LU);
        tick(); id_uses_rt = 1'b0;
        #2 check_lit("load_use_rt_unused", L_DEF);

        // Branch wins over load-use
        tick(); idex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1;
        #2 check_lit("branch_vs_lu", L_BR);

        // Memory wait: 3 frozen cycles then ready
        tick(); set_idle(); dmem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 check_lit("memwait_frozen", L_FRZ);
            tick();
        end
        dmem_ready = 1'b1;
        #2 check_lit("memwait_release", L_DEF);
        tick(); set_idle();
        #2 check_lit("memwait_no_err", L_DEF);

        // Timeout: 16 frozen cycles, release on the 17th, sticky error
        tick(); dmem_req = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #2 check_lit("timeout_frozen", L_FRZ);
            tick();
        end
        #2 check_lit("timeout_release", L_DEF);
        tick(); set_idle();
        #2 check_lit("timeout_err_set", L_DEF_E);
        tick();
        #2 check_lit("timeout_err_sticky", L_DEF_E);

        // Halt pulse: enter, 4 drain cycles, halted, resume
        tick(); halt_req = 1'b1;
        #2 check_lit("halt_enter", L_HENT_E);
        tick(); halt_req = 1'b0;
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            #2 check_lit("drain", L_DRN_E);
            tick();
        end
        #2 check_lit("halted", L_HLT_E);
        tick();
        #2 check_lit("resume", L_DEF_E);

        // Async reset in the middle of a memory wait
        tick(); dmem_req = 1'b1;
        #2 check_lit("pre_rst_frozen", L_FRZ_E);
        tick();
        #1 check_lit("pre_rst_wait", L_FRZ_E);
        #1 reset_n = 1'b0;
        #1 check_lit("async_reset", L_DEF);
        tick(); reset_n = 1'b1; set_idle();
        #2 check_lit("post_reset", L_DEF);

        // Randomized traffic; the compare process does the checking
        for (int c = 0; c < 3000; c++) begin
            tick();
            id_rs           = 5'($urandom_range(0, 7));
            id_rt           = 5'($urandom_range(0, 7));
            idex_rt         = 5'($urandom_range(0, 7));
            id_uses_rt      = 1'($urandom_range(0, 1));
            idex_memread    = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            dmem_req        = ($urandom_range(0, 3) == 0);
            dmem_ready      = ((c % 400) >= 40) && ($urandom_range(0, 2) == 0);
            halt_req        = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset_n = 1'b0;
                #1 reset_n = 1'b1;
            end
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
